// File: rtl/act_cfg_loader.sv
// -----------------------------------------------------------------------------
// act_cfg_loader
//
// Serial configuration loader for the ACT logic-cell array. It shifts a framed,
// bit-serial stream into a shadow register and commits the whole word at once
// onto cfg_word. cfg_word drives the D00/D01/D10/D11 constant pins of
// NUM_CELLS mux cells, so the cells never see a partially loaded frame.
//
// Optional feature macro: CFG_PARITY_EN
//   defined   : each frame carries a trailing even-parity bit. The bit is
//               checked in the PARITY state. A mismatch sets cfg_err and
//               discards the frame.
//   undefined : the frame is data only, and SHIFT goes straight to COMMIT.
//
// Ports
//   clk        in   rising-edge clock
//   clr        in   asynchronous active-low reset
//   cfg_start  in   one-cycle pulse that opens a new frame (aborts an open one)
//   cfg_valid  in   qualifies cfg_bit
//   cfg_bit    in   serial data bit, sent LSB first (cell 0 D00 first)
//   cfg_ready  out  loader can take a bit this cycle
//   cfg_word   out  committed constants; [4i+3:4i] = {D11,D10,D01,D00} of cell i
//   cfg_done   out  one-cycle pulse on a successful commit
//   cfg_err    out  sticky frame-error flag, cleared by the next cfg_start
//   busy       out  frame open (SHIFT or PARITY)
//   dbg_state  out  current FSM state (IDLE=0, SHIFT=1, PARITY=2, COMMIT=3)
//
// Handshake: a bit is transferred on a rising edge where cfg_valid && cfg_ready
// is true. cfg_valid may stay low for any number of cycles inside a frame.
// cfg_ready does not depend on cfg_valid. A cycle with cfg_start high never
// transfers a bit, because the start takes priority over the bit.
// -----------------------------------------------------------------------------
module act_cfg_loader #(
    parameter int NUM_CELLS = 8
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   cfg_start,
    input  logic                   cfg_valid,
    input  logic                   cfg_bit,
    output logic                   cfg_ready,
    output logic [4*NUM_CELLS-1:0] cfg_word,
    output logic                   cfg_done,
    output logic                   cfg_err,
    output logic                   busy,
    output logic [1:0]             dbg_state
);

    localparam int W     = 4 * NUM_CELLS;
    localparam int CNT_W = $clog2(W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     shadow;
    logic [W-1:0]     shadow_next;
    logic             xfer;
`ifdef CFG_PARITY_EN
    logic             par;      // running XOR of the data bits accepted so far
`endif

    assign xfer      = cfg_valid && cfg_ready;
    assign dbg_state = state;

    // The shadow is cleared when a frame opens, so OR-ing in the new bit at
    // position cnt is enough. It also gives the full word in the same cycle
    // as the last data bit.
    assign shadow_next = shadow | (W'(cfg_bit) << cnt);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            cnt       <= '0;
            shadow    <= '0;
            cfg_word  <= '0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b0;
`ifdef CFG_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            cfg_done  <= 1'b0;
            cfg_ready <= 1'b1;

            if (cfg_start && (state != COMMIT)) begin
                // Open a new frame. When this start aborts an open frame, the
                // abort error is overridden by the clear that every start
                // performs. The net result is cfg_err = 0.
                state   <= SHIFT;
                cnt     <= '0;
                shadow  <= '0;
                cfg_err <= 1'b0;
                busy    <= 1'b1;
`ifdef CFG_PARITY_EN
                par     <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        // cfg_valid without cfg_start is ignored.
                        busy <= 1'b0;
                    end

                    SHIFT: begin
                        if (xfer) begin
                            shadow <= shadow_next;
                            cnt    <= cnt + CNT_W'(1);
`ifdef CFG_PARITY_EN
                            par    <= par ^ cfg_bit;
`endif
                            if (cnt == LAST) begin
`ifdef CFG_PARITY_EN
                                state <= PARITY;
`else
                                state     <= COMMIT;
                                cfg_word  <= shadow_next;
                                cfg_done  <= 1'b1;
                                cfg_ready <= 1'b0;
                                busy      <= 1'b0;
`endif
                            end
                        end
                    end

`ifdef CFG_PARITY_EN
                    PARITY: begin
                        if (xfer) begin
                            busy <= 1'b0;
                            // Even parity: the data XOR and the parity bit must cancel.
                            if ((par ^ cfg_bit) == 1'b0) begin
                                state     <= COMMIT;
                                cfg_word  <= shadow;
                                cfg_done  <= 1'b1;
                                cfg_ready <= 1'b0;
                            end else begin
                                state   <= IDLE;
                                cfg_err <= 1'b1;
                            end
                        end
                    end
`endif

                    COMMIT: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_act_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_act_cfg_loader
//
// Directed bench for act_cfg_loader. Each scenario task drives a frame and
// checks the outputs inline against hand-computed values. Inputs change on
// the falling edge, and outputs are sampled on the falling edge. When
// CFG_PARITY_EN is defined, frames carry the even-parity bit, and the
// parity-error scenario is included.
// -----------------------------------------------------------------------------
module tb_act_cfg_loader;

    localparam int NUM_CELLS = 8;
    localparam int W         = 4 * NUM_CELLS;

    // clock / reset
    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    logic           cfg_start;
    logic           cfg_valid;
    logic           cfg_bit;
    logic           cfg_ready;
    logic [W-1:0]   cfg_word;
    logic           cfg_done;
    logic           cfg_err;
    logic           busy;
    logic [1:0]     dbg_state;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    act_cfg_loader #(.NUM_CELLS(NUM_CELLS)) dut (
        .clk       (clk),
        .clr       (clr),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .cfg_word  (cfg_word),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Count every cfg_done pulse, so that extra or missing commits are caught.
    always @(negedge clk) begin
        if (cfg_done === 1'b1) done_cnt = done_cnt + 1;
    end

    // Driver: pulse cfg_start, then send nbits data bits of word LSB first.
    // For a full frame in parity builds, also send the parity bit, inverted
    // when par_flip is set. gaps inserts random idle cycles with garbage on
    // cfg_bit. start_valid also raises cfg_valid (with cfg_bit = 1) in the
    // start cycle. The task returns on the falling edge after the final
    // accepting rising edge.
    task automatic drive_frame(input logic [W-1:0] word, input int nbits,
                               input logic par_flip, input logic gaps,
                               input logic start_valid);
        done_cnt = 0;
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_valid = start_valid;
        cfg_bit   = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                cfg_valid = 1'b0;
                cfg_bit   = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            cfg_valid = 1'b1;
            cfg_bit   = word[i];
            @(negedge clk);
        end
`ifdef CFG_PARITY_EN
        if (nbits == W) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                cfg_valid = 1'b0;
                @(negedge clk);
            end
            cfg_valid = 1'b1;
            cfg_bit   = (^word) ^ par_flip;
            @(negedge clk);
        end
`else
        if (par_flip) $display("note: parity flip ignored, parity disabled");
`endif
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
    endtask

    task automatic test_reset;
        clr = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (cfg_word !== '0) begin errors++; $display("FAIL reset_word: got %h expected 0", cfg_word); end
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", cfg_done); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", cfg_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", cfg_ready); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        clr = 1'b1;
        #1;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b expected 0", cfg_ready); end
        @(negedge clk);
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %b expected 1", cfg_ready); end
    endtask

    task automatic test_commit;
        logic [W-1:0] exp_word;
        exp_word = 32'hA5C3_0F96;
        drive_frame(exp_word, W, 1'b0, 1'b0, 1'b0);
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL commit_done_latency: got %b expected 1", cfg_done); end
        checks++; if (cfg_word !== exp_word) begin errors++; $display("FAIL commit_word: got %h expected %h", cfg_word, exp_word); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL commit_ready: got %b expected 0", cfg_ready); end
        checks++; if (dbg_state !== 2'd3) begin errors++; $display("FAIL commit_state: got %0d expected 3", dbg_state); end
        // A start raised during COMMIT is ignored.
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL start_in_commit_state: got %0d expected 0", dbg_state); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_commit_busy: got %b expected 0", busy); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL commit_done_count: got %0d expected 1", done_cnt); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", cfg_ready); end
    endtask

`ifdef CFG_PARITY_EN
    task automatic test_parity_err;
        drive_frame(32'h0F0F_0F0F, W, 1'b1, 1'b0, 1'b0);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL parity_err_flag: got %b expected 1", cfg_err); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL parity_err_state: got %0d expected 0", dbg_state); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL parity_err_busy: got %b expected 0", busy); end
        @(negedge clk);
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL parity_err_done_count: got %0d expected 0", done_cnt); end
        checks++; if (cfg_word !== 32'hA5C3_0F96) begin errors++; $display("FAIL parity_err_word_kept: got %h expected a5c30f96", cfg_word); end
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL parity_err_sticky: got %b expected 1", cfg_err); end
    endtask
`endif

    task automatic test_gaps;
        logic [W-1:0] exp_word;
        exp_word = 32'h1234_5678;
        drive_frame(exp_word, W, 1'b0, 1'b1, 1'b0);
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL gaps_done: got %b expected 1", cfg_done); end
        checks++; if (cfg_word !== exp_word) begin errors++; $display("FAIL gaps_word: got %h expected %h", cfg_word, exp_word); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL gaps_err_cleared: got %b expected 0", cfg_err); end
        @(negedge clk);
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL gaps_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_idle_ignore;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = 1'b1;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        @(negedge clk);
        checks++; if (cfg_word !== 32'h1234_5678) begin errors++; $display("FAIL idle_word: got %h expected 12345678", cfg_word); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL idle_state: got %0d expected 0", dbg_state); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL idle_done_count: got %0d expected 0", done_cnt); end
    endtask

    task automatic test_abort;
        logic [W-1:0] exp_word;
        exp_word = 32'hFFFF_0000;
        // Ten ones land on bit positions that the next frame sets to zero.
        drive_frame(32'hFFFF_FFFF, 10, 1'b0, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_open: got %b expected 1", busy); end
        checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL abort_state_shift: got %0d expected 1", dbg_state); end
        drive_frame(exp_word, W, 1'b0, 1'b0, 1'b0);
        checks++; if (cfg_word !== exp_word) begin errors++; $display("FAIL abort_word: got %h expected %h", cfg_word, exp_word); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL abort_err_net: got %b expected 0", cfg_err); end
        @(negedge clk);
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL abort_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_start_with_valid;
        drive_frame('0, W, 1'b0, 1'b0, 1'b1);
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL startvalid_done: got %b expected 1", cfg_done); end
        checks++; if (cfg_word !== '0) begin errors++; $display("FAIL startvalid_word: got %h expected 0", cfg_word); end
        @(negedge clk);
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL startvalid_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_reset_mid_frame;
        drive_frame(32'hCAFE_F00D, W, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive_frame(32'hFFFF_FFFF, 12, 1'b0, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
        #2;
        clr = 1'b0;
        #1;
        checks++; if (cfg_word !== '0) begin errors++; $display("FAIL midreset_word: got %h expected 0", cfg_word); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", cfg_done); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL midreset_err: got %b expected 0", cfg_err); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b expected 0", cfg_ready); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL midreset_state: got %0d expected 0", dbg_state); end
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready_release: got %b expected 1", cfg_ready); end
        checks++; if (cfg_word !== '0) begin errors++; $display("FAIL midreset_word_release: got %h expected 0", cfg_word); end
    endtask

    initial begin
        test_reset();
        test_commit();
`ifdef CFG_PARITY_EN
        test_parity_err();
`endif
        test_gaps();
        test_idle_ignore();
        test_abort();
        test_start_with_valid();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
